// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register state encoding and default WB control bit positions
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;
    localparam int RW     = 0;
    localparam int MTR_LO = 1;
    localparam int MTR_HI = 2;
    localparam int HB     = 3;
endpackage

// File: rtl/wb_stage_skid_reg.sv
// wb_stage_skid_reg: valid/ready pipeline register with one-entry skid buffer, flush and bubble control kill
module wb_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int N_DATA = 3,
    parameter int RD_W   = 5,
    parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = 4'b0001
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Flush,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [CTRL_W-1:0]        In_Ctrl,
    input  logic [N_DATA*DATA_W-1:0] In_Data,
    input  logic [RD_W-1:0]          In_RegDst,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [CTRL_W-1:0]        Out_Ctrl,
    output logic [N_DATA*DATA_W-1:0] Out_Data,
    output logic [RD_W-1:0]          Out_RegDst,
    output logic [1:0]               Occupancy
);
    localparam int DW = N_DATA * DATA_W;
    localparam int PW = CTRL_W + RD_W + DW;
    state_t state, state_n;
    logic [PW-1:0] m, s, in_p;
    logic accept, pop, load_m, load_s, use_s;
    assign in_p      = {In_Ctrl, In_RegDst, In_Data};
    assign In_Ready  = state != FULL2;
    assign Out_Valid = state != EMPTY;
    assign Occupancy = state;
    assign accept    = In_Valid & In_Ready;
    assign pop       = Out_Valid & Out_Ready;
    // a bubble must never carry live control such as RegWrite
    assign Out_Ctrl   = m[PW-1 -: CTRL_W] & ~(CTRL_KILL_MASK & {CTRL_W{~Out_Valid}});
    assign Out_RegDst = m[DW +: RD_W];
    assign Out_Data   = m[DW-1:0];
    always_comb begin
        state_n = state;
        load_m  = 1'b0;
        load_s  = 1'b0;
        use_s   = 1'b0;
        if (Flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_n = accept ? FULL1 : EMPTY;
                    load_m  = accept;
                end
                FULL1: begin
                    state_n = accept ? (pop ? FULL1 : FULL2) : (pop ? EMPTY : FULL1);
                    load_m  = accept & pop;
                    load_s  = accept & ~pop;
                end
                FULL2: begin
                    state_n = pop ? FULL1 : FULL2;
                    load_m  = pop;
                    use_s   = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= EMPTY;
            m     <= '0;
            s     <= '0;
        end else begin
            state <= state_n;
            if (load_m) m <= use_s ? s : in_p;
            if (load_s) s <= in_p;
        end
    end
endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// tb_wb_stage_skid_reg: table-driven and directed checks of wb_stage_skid_reg (default and narrow configurations)
module tb_wb_stage_skid_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [3:0]  in_ctrl = '0, out_ctrl;
    logic [95:0] in_data = '0, out_data;
    logic [4:0]  in_rd = '0, out_rd;
    logic [1:0]  occ;
    logic        n_in_valid = 1'b0, n_out_ready = 1'b0, n_in_ready, n_out_valid;
    logic [1:0]  n_in_ctrl = '0, n_out_ctrl, n_occ;
    logic [15:0] n_in_data = '0, n_out_data;
    logic [4:0]  n_in_rd = '0, n_out_rd;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    wb_stage_skid_reg dut (
        .Clk(clk), .Reset(rst_n), .Flush(flush),
        .In_Valid(in_valid), .In_Ready(in_ready), .In_Ctrl(in_ctrl), .In_Data(in_data), .In_RegDst(in_rd),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Ctrl(out_ctrl), .Out_Data(out_data), .Out_RegDst(out_rd),
        .Occupancy(occ)
    );
    wb_stage_skid_reg #(.CTRL_W(2), .DATA_W(16), .N_DATA(1), .RD_W(5), .CTRL_KILL_MASK(2'b11)) dut_n (
        .Clk(clk), .Reset(rst_n), .Flush(1'b0),
        .In_Valid(n_in_valid), .In_Ready(n_in_ready), .In_Ctrl(n_in_ctrl), .In_Data(n_in_data), .In_RegDst(n_in_rd),
        .Out_Valid(n_out_valid), .Out_Ready(n_out_ready), .Out_Ctrl(n_out_ctrl), .Out_Data(n_out_data), .Out_RegDst(n_out_rd),
        .Occupancy(n_occ)
    );
    typedef struct {
        int rst, fl, iv, ordy, rd;
        int ov, ir, oc, erd, ectrl;
    } vec_t;
    vec_t vt[22];
    function automatic logic [95:0] dat(input int r);
        logic [31:0] w = 32'(r);
        return r == 0 ? 96'd0 : {32'hC000_0000 | w, 32'hB000_0000 | w, 32'hA000_0000 | w};
    endfunction
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input int rst, input int fl, input int iv, input int ordy, input int rd);
        rst_n     = rst != 0;
        flush     = fl != 0;
        in_valid  = iv != 0;
        out_ready = ordy != 0;
        in_rd     = 5'(rd);
        in_ctrl   = {3'(rd), 1'b1};
        in_data   = dat(rd);
    endtask
    task automatic expect_out(input string tag, input int ov, input int ir, input int oc, input int erd, input int ectrl);
        chk({tag, ".valid"}, 96'(out_valid), 96'(ov));
        chk({tag, ".ready"}, 96'(in_ready), 96'(ir));
        chk({tag, ".occ"}, 96'(occ), 96'(oc));
        chk({tag, ".rd"}, 96'(out_rd), 96'(erd));
        chk({tag, ".ctrl"}, 96'(out_ctrl), 96'(ectrl));
        chk({tag, ".data"}, out_data, dat(erd));
    endtask
    initial begin
        vt = '{
            '{0,0,1,0, 7,  0,1,0, 0,'h0},
            '{0,0,1,0, 7,  0,1,0, 0,'h0},
            '{1,0,1,1, 1,  1,1,1, 1,'h3},
            '{1,0,1,1, 2,  1,1,1, 2,'h5},
            '{1,0,1,1, 3,  1,1,1, 3,'h7},
            '{1,0,0,1, 0,  0,1,0, 3,'h6},
            '{1,0,1,0, 4,  1,1,1, 4,'h9},
            '{1,0,1,0, 5,  1,0,2, 4,'h9},
            '{1,0,1,0, 6,  1,0,2, 4,'h9},
            '{1,0,1,1, 6,  1,1,1, 5,'hB},
            '{1,0,1,1, 6,  1,1,1, 6,'hD},
            '{1,0,0,1, 0,  0,1,0, 6,'hC},
            '{1,0,1,0, 8,  1,1,1, 8,'h1},
            '{1,0,1,0, 9,  1,0,2, 8,'h1},
            '{1,1,1,0,10,  0,1,0, 8,'h0},
            '{1,0,0,0, 0,  0,1,0, 8,'h0},
            '{1,0,1,0,11,  1,1,1,11,'h7},
            '{1,1,1,1,12,  0,1,0,11,'h6},
            '{1,0,1,0,13,  1,1,1,13,'hB},
            '{1,0,1,0,14,  1,0,2,13,'hB},
            '{0,0,0,0, 0,  0,1,0, 0,'h0},
            '{1,0,1,0,15,  1,1,1,15,'hF}
        };
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].rd);
            @(posedge clk);
            #1;
            expect_out($sformatf("vec%0d", i), vt[i].ov, vt[i].ir, vt[i].oc, vt[i].erd, vt[i].ectrl);
        end
        // streaming from FULL1 holding 15: each push replaces M with no bubble
        for (int r = 16; r <= 20; r++) begin
            @(negedge clk);
            drive(1, 0, 1, 1, r);
            @(posedge clk);
            #1;
            expect_out($sformatf("stream%0d", r), 1, 1, 1, r, (((r & 7) << 1) | 1));
        end
        @(negedge clk);
        drive(1, 0, 1, 0, 21);
        @(posedge clk);
        #1;
        expect_out("bp0", 1, 0, 2, 20, 'h9);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk("ready_no_comb_path", 96'(in_ready), 96'd0);
        @(posedge clk);
        #1;
        expect_out("bp1", 1, 1, 1, 21, 'hB);
        @(negedge clk);
        drive(1, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        expect_out("bp2", 0, 1, 0, 21, 'hA);
        // narrow configuration: 16-bit data, every control bit killed on bubbles
        @(negedge clk);
        n_in_valid = 1'b1;
        n_in_ctrl  = 2'b11;
        n_in_data  = 16'hBEEF;
        n_in_rd    = 5'd3;
        @(posedge clk);
        #1;
        chk("n.valid", 96'(n_out_valid), 96'd1);
        chk("n.ctrl", 96'(n_out_ctrl), 96'h3);
        chk("n.data", 96'(n_out_data), 96'hBEEF);
        chk("n.rd", 96'(n_out_rd), 96'd3);
        @(negedge clk);
        n_in_valid  = 1'b0;
        n_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("n.bubble_valid", 96'(n_out_valid), 96'd0);
        chk("n.bubble_ctrl", 96'(n_out_ctrl), 96'h0);
        chk("n.bubble_data", 96'(n_out_data), 96'hBEEF);
        chk("n.occ", 96'(n_occ), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_stage_skid_reg.md
# wb_stage_skid_reg

Parametrised successor to the MEM/WB pipeline register. It carries a control field, N_DATA data words and a destination-register index from one pipeline stage to the next. It adds a valid/ready handshake, a one-entry skid buffer for back-pressure, a flush, and control-bit killing on bubbles. It sits between any two pipeline stages, with MEM→WB as the first user, and replaces free-running stage registers where stalls or squashes are needed.

## Interface
- CTRL_W, 4: control field width (WB use: bit0 RegWrite, bits2:1 MemToReg, bit3 halfbyte)
- DATA_W, 32: width of one data word
- N_DATA, 3: number of data words carried (WB use: Read, ALUResult, PCAddResult)
- RD_W, 5: destination-register index width
- CTRL_KILL_MASK, 4'b0001: control bits forced to 0 whenever Out_Valid=0

Ports:
- Clk, input, 1: clock, all state updates on rising edge
- Reset, input, 1: synchronous, active-low (0 = reset), sampled on rising edge of Clk
- Flush, input, 1: squash all held entries
- In_Valid, input, 1: upstream entry present
- In_Ready, output, 1: block can accept an entry this cycle
- In_Ctrl, input, CTRL_W: control field
- In_Data, input, N_DATA*DATA_W: data words, word k at [k*DATA_W +: DATA_W]
- In_RegDst, input, RD_W: destination register
- Out_Valid, output, 1: output entry present
- Out_Ready, input, 1: downstream consumes entry
- Out_Ctrl, output, CTRL_W: control field, masked per CTRL_KILL_MASK
- Out_Data, output, N_DATA*DATA_W: data words
- Out_RegDst, output, RD_W: destination register
- Occupancy, output, 2: entries held (0..2)

## Operation
- Storage: main entry M, which drives the outputs, and skid entry S.
- accept = In_Valid & In_Ready. pop = Out_Valid & Out_Ready.
- States and transitions:
  - EMPTY
    - accept → FULL1, M←in.
  - FULL1
    - accept & ~pop → FULL2, S←in.
    - accept & pop → FULL1, M←in.
    - ~accept & pop → EMPTY.
    - otherwise hold.
  - FULL2
    - pop → FULL1, M←S.
    - otherwise hold. accept cannot occur in FULL2.
- In_Ready = (state != FULL2). It is a function of the state register only; there is no combinational path from Out_Ready.
- Out_Valid = (state != EMPTY).
- Occupancy values: 0 for EMPTY, 1 for FULL1, 2 for FULL2.
- Out_Ctrl = M.ctrl & ~(CTRL_KILL_MASK & {CTRL_W{~Out_Valid}}). A bubble therefore never asserts RegWrite.
- Out_Data and Out_RegDst always present M unmasked.
- Flush: next state EMPTY, regardless of accept/pop.
  - An entry presented with In_Valid in a Flush cycle is dropped.
  - A pop in a Flush cycle still counts as a completed transfer.
  - Payload registers are not cleared by Flush.
- Priority: Reset > Flush > handshake.
- Entries leave in arrival order; none is duplicated or lost except by Flush or Reset.

## Timing
- Reset values (edge with Reset=0):
  - state EMPTY, Out_Valid 0, In_Ready 1, Occupancy 0
  - Out_Ctrl 0, Out_Data 0, Out_RegDst 0
  - S payload 0
- Reset mid-operation discards all entries at that edge.
- Latency: entry accepted at edge t is on the outputs with Out_Valid=1 after edge t, i.e. available to the consumer in cycle t+1.
- Throughput: 1 entry/cycle with Out_Ready held 1; no bubbles.
- Out_Ready deasserted for one cycle while streaming: the block absorbs one entry into S and In_Ready drops the following cycle.
- After a Flush edge: Out_Valid=0, In_Ready=1 and Occupancy=0 in the next cycle.

## Structure
- Shared package pipe_pkg holds:
  - state typedef: EMPTY=2'd0, FULL1=2'd1, FULL2=2'd2
  - default WB control bit positions: RW=0, MTR=2:1, HB=3
- Single module; payload for M and S as one packed {ctrl, regdst, data} vector of CTRL_W+RD_W+N_DATA*DATA_W bits.
- No sub-module.

## Test plan
- Reset: Reset=0 for 2 cycles with In_Valid=1, In_Ctrl=4'hF → Out_Valid=0, Out_Ctrl=0, Out_Data=0, Out_RegDst=0, In_Ready=1, Occupancy=0.
- Streaming: Out_Ready=1, push regdst 1,2,3 on consecutive cycles → Out_RegDst 1,2,3 on the following consecutive cycles, Out_Valid continuous, Occupancy never 2.
- Back-pressure: Out_Ready=0, push A, B → Occupancy=2 and In_Ready=0, so C is held upstream. Then Out_Ready=1 → A, B, C emerge in order with no loss or duplicates.
- Flush: in FULL2, assert Flush with In_Valid=1 carrying D → next cycle Out_Valid=0, Out_Ctrl[0]=0, Occupancy=0, In_Ready=1; D never appears at the output.
- Reset mid-operation: in FULL2, pulse Reset=0 for one edge → all outputs at reset values next cycle; a new push then appears after 1 cycle.
- Parameters: N_DATA=1, DATA_W=16, CTRL_W=2, CTRL_KILL_MASK=2'b11 → 16-bit data passes intact, and Out_Ctrl=0 whenever Out_Valid=0.
